melody_sequencer: RTL and testbench

- Sequences the speaker square-wave tone datapath through a small programmable note table.
- Each table entry holds a half-period divider, a duration and a last-note flag.
- The block replays the table once or in a loop and drives the differential speaker pins directly.
- Sits between the PLL clock domain (25 MHz) and the spkp/spkm pads; a host FSM or ROM loader fills the table.

---
 rtl/melody_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_melody_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - note-table tone sequencer driving differential speaker pins
//
// Plays a small programmable note table as a square wave on spkp/spkm.
// Each entry holds a half-period divider, a duration in ticks and a last flag.
// The table is written only while the sequencer is idle.
//
// Ports:
//   clk       system clock; all logic runs on posedge
//   resetn    asynchronous active-low reset
//   wr_en     table write strobe (honoured only in IDLE)
//   wr_addr   table write address
//   wr_div    half-period in clk cycles, 0 = rest
//   wr_dur    note length in ticks, 0 = skip entry
//   wr_last   entry ends the melody
//   start     begin playback at entry 0 (pulse)
//   stop      abort playback (pulse); overrides everything else
//   loop      sampled at end of melody: 1 = restart at entry 0
//   busy      high in LOAD/PLAY/GAP
//   done      one-cycle pulse on normal completion
//   note_idx  entry currently loaded/playing
//   spkp/spkm differential speaker drive, both 0 when silent
module melody_sequencer #(
  parameter int CLK_HZ    = 25000000,
  parameter int TICK_HZ   = 1000,
  parameter int DEPTH     = 16,
  parameter int DIV_W     = 16,
  parameter int DUR_W     = 8,
  parameter int GAP_TICKS = 10,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic             wr_last,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    note_idx,
  output logic             spkp,
  output logic             spkm
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // +2 keeps the width at least 1 bit when GAP_TICKS is 0
  localparam int GW       = $clog2(GAP_TICKS + 2);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(DEPTH - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DIV_W-1:0] div_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem [DEPTH];
  logic [DEPTH-1:0] last_mem;

  logic [AW-1:0]    idx_q, idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             last_q, last_d;
  logic [DIV_W-1:0] tone_cnt_q, tone_cnt_d;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             tone_q, tone_d;
  logic             done_q, done_d;

  logic             advance;
  logic             end_last;
  logic [DIV_W-1:0] rd_div;
  logic [DUR_W-1:0] rd_dur;
  logic             rd_last;

  // Table storage is deliberately not reset so a reset mid-melody keeps the tune.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == ST_IDLE)) begin
      div_mem[wr_addr]  <= wr_div;
      dur_mem[wr_addr]  <= wr_dur;
      last_mem[wr_addr] <= wr_last;
    end
  end

  assign rd_div  = div_mem[idx_q];
  assign rd_dur  = dur_mem[idx_q];
  assign rd_last = last_mem[idx_q];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    div_d      = div_q;
    last_d     = last_q;
    tone_cnt_d = tone_cnt_q;
    tick_cnt_d = tick_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tone_d     = tone_q;
    done_d     = 1'b0;
    advance    = 1'b0;
    end_last   = last_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end

      ST_LOAD: begin
        div_d      = rd_div;
        last_d     = rd_last;
        tone_d     = 1'b0;
        tone_cnt_d = (rd_div == '0) ? '0 : rd_div - 1'b1;
        tick_cnt_d = TICK_LAST;
        dur_cnt_d  = rd_dur;
        if (rd_dur == '0) begin
          // Skipped entries must honour their own last flag, not the latched one.
          advance  = 1'b1;
          end_last = rd_last;
        end else begin
          state_d = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (div_q != '0) begin
          if (tone_cnt_q == '0) begin
            tone_cnt_d = div_q - 1'b1;
            tone_d     = ~tone_q;
          end else begin
            tone_cnt_d = tone_cnt_q - 1'b1;
          end
        end
        if (tick_cnt_q == '0) begin
          tick_cnt_d = TICK_LAST;
          dur_cnt_d  = dur_cnt_q - 1'b1;
          if (dur_cnt_q == DUR_W'(1)) begin
            if (GAP_TICKS == 0) begin
              advance = 1'b1;
            end else begin
              state_d   = ST_GAP;
              gap_cnt_d = GAP_LOAD;
            end
          end
        end else begin
          tick_cnt_d = tick_cnt_q - 1'b1;
        end
      end

      ST_GAP: begin
        if (tick_cnt_q == '0) begin
          tick_cnt_d = TICK_LAST;
          gap_cnt_d  = gap_cnt_q - 1'b1;
          if (gap_cnt_q == GW'(1)) begin
            advance = 1'b1;
          end
        end else begin
          tick_cnt_d = tick_cnt_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (end_last || (idx_q == IDX_LAST)) begin
        if (loop) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end else begin
        state_d = ST_LOAD;
        idx_d   = idx_q + 1'b1;
      end
    end

    if (stop) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      tone_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      div_q      <= '0;
      last_q     <= 1'b0;
      tone_cnt_q <= '0;
      tick_cnt_q <= '0;
      dur_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      tone_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      div_q      <= div_d;
      last_q     <= last_d;
      tone_cnt_q <= tone_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tone_q     <= tone_d;
      done_q     <= done_d;
    end
  end

  // Pins decode straight from state so an async reset silences them at once.
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign note_idx = idx_q;
  assign spkp     = (state_q == ST_PLAY) && tone_q;
  assign spkm     = (state_q == ST_PLAY) && (div_q != '0) && !tone_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - self-checking bench for melody_sequencer
module tb_melody_sequencer;

  localparam int TD   = 10;
  localparam int GAPT = 1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_div;
  logic [7:0]  wr_dur;
  logic        wr_last;
  logic        start;
  logic        stop;
  logic        loop;
  logic        busy;
  logic        done;
  logic [1:0]  note_idx;
  logic        spkp;
  logic        spkm;

  int checks   = 0;
  int failures = 0;

  int m_div [4];
  int m_dur [4];
  bit m_last [4];

  // expected observation per cycle: {busy, spkp, spkm, note_idx[1:0], done}
  logic [5:0] exp_q [$];

  melody_sequencer #(
    .CLK_HZ(1000), .TICK_HZ(100), .DEPTH(4), .DIV_W(16), .DUR_W(8), .GAP_TICKS(GAPT)
  ) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_div(wr_div),
    .wr_dur(wr_dur), .wr_last(wr_last), .start(start), .stop(stop), .loop(loop),
    .busy(busy), .done(done), .note_idx(note_idx), .spkp(spkp), .spkm(spkm)
  );

  always #5 clk = ~clk;

  function automatic void push(input bit b, input bit p, input bit m, input int idx, input bit d);
    logic [1:0] i2;
    i2 = idx[1:0];
    exp_q.push_back({b, p, m, i2, d});
  endfunction

  // Timeline of the melody derived from the note rules, one entry per clk after start.
  function automatic void build_trace(input bit loop_v, input int limit);
    int idx;
    bit tone;
    exp_q.delete();
    idx = 0;
    while (exp_q.size() < limit) begin
      push(1, 0, 0, idx, 0);
      if (m_dur[idx] != 0) begin
        for (int t = 0; t < m_dur[idx] * TD; t++) begin
          if (m_div[idx] == 0) push(1, 0, 0, idx, 0);
          else begin
            tone = ((t / m_div[idx]) % 2) == 1;
            push(1, tone, !tone, idx, 0);
          end
        end
        for (int t = 0; t < GAPT * TD; t++) push(1, 0, 0, idx, 0);
      end
      if (m_last[idx] || idx == 3) begin
        if (loop_v) idx = 0;
        else begin
          push(0, 0, 0, idx, 1);
          push(0, 0, 0, idx, 0);
          break;
        end
      end else begin
        idx++;
      end
    end
  endfunction

  function automatic string fname(input int k);
    case (k)
      0: return "busy";
      1: return "spkp_spkm";
      2: return "note_idx";
      default: return "done";
    endcase
  endfunction

  task automatic write_entry(input int a, input int d, input int u, input bit l);
    wr_en = 1; wr_addr = a[1:0]; wr_div = d[15:0]; wr_dur = u[7:0]; wr_last = l;
    @(negedge clk);
    wr_en = 0;
    m_div[a] = d; m_dur[a] = u; m_last[a] = l;
  endtask

  // inj_kind: 1 = start pulse while busy, 2 = write entry 0 with div=7 while busy
  task automatic run_trace(input string name, input bit loop_v, input int limit,
                           input int inj_at, input int inj_kind);
    int n;
    int err [4];
    int fcyc [4];
    logic [1:0] fact [4];
    logic [1:0] fexp [4];
    logic [1:0] av [4];
    logic [1:0] ev [4];
    logic [5:0] a;
    logic [5:0] e;
    build_trace(loop_v, limit);
    n = (limit < exp_q.size()) ? limit : exp_q.size();
    for (int k = 0; k < 4; k++) begin err[k] = 0; fcyc[k] = 0; fact[k] = 0; fexp[k] = 0; end
    loop = loop_v;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      start = 0; wr_en = 0;
      a = {busy, spkp, spkm, note_idx, done};
      e = exp_q[i];
      av[0] = {1'b0, a[5]}; av[1] = a[4:3]; av[2] = a[2:1]; av[3] = {1'b0, a[0]};
      ev[0] = {1'b0, e[5]}; ev[1] = e[4:3]; ev[2] = e[2:1]; ev[3] = {1'b0, e[0]};
      for (int k = 0; k < 4; k++) begin
        if (av[k] !== ev[k]) begin
          if (err[k] == 0) begin fcyc[k] = i; fact[k] = av[k]; fexp[k] = ev[k]; end
          err[k]++;
        end
      end
      if (i == inj_at) begin
        if (inj_kind == 1) start = 1;
        if (inj_kind == 2) begin
          wr_en = 1; wr_addr = 0; wr_div = 7; wr_dur = 3; wr_last = 0;
        end
      end
    end
    start = 0; wr_en = 0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (err[k] != 0) begin
        failures++;
        $display("FAIL %s/%s: %0d cycles differ, first at cycle %0d actual=%0d required=%0d",
                 name, fname(k), err[k], fcyc[k], fact[k], fexp[k]);
      end
    end
  endtask

  task automatic test_reset();
    resetn = 0; wr_en = 0; wr_addr = 0; wr_div = 0; wr_dur = 0; wr_last = 0;
    start = 0; stop = 0; loop = 0;
    #3;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: actual=%b required=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: actual=%b required=0", done); end
    checks++; if (note_idx !== 2'd0) begin failures++; $display("FAIL reset_idx: actual=%0d required=0", note_idx); end
    checks++; if (spkp !== 1'b0) begin failures++; $display("FAIL reset_spkp: actual=%b required=0", spkp); end
    checks++; if (spkm !== 1'b0) begin failures++; $display("FAIL reset_spkm: actual=%b required=0", spkm); end
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    write_entry(0, 2, 3, 0);
    write_entry(1, 0, 2, 1);
    write_entry(2, 5, 1, 0);
    write_entry(3, 5, 1, 0);
    run_trace("basic", 0, 100000, 5, 1);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_after: busy actual=%b required=0", busy); end
  endtask

  task automatic test_skip();
    write_entry(0, 2, 3, 0);
    write_entry(1, 3, 0, 0);
    write_entry(2, 1, 2, 1);
    run_trace("skip", 0, 100000, -1, 0);
  endtask

  task automatic test_loop_stop();
    int bad;
    write_entry(0, 2, 3, 0);
    write_entry(1, 0, 2, 1);
    write_entry(2, 0, 0, 0);
    run_trace("loop", 1, 80, -1, 0);
    stop = 1;
    @(negedge clk);
    stop = 0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_busy: actual=%b required=0", busy); end
    checks++; if ({spkp, spkm} !== 2'b00) begin failures++; $display("FAIL stop_pins: actual=%b required=00", {spkp, spkm}); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL stop_done: actual=%b required=0", done); end
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stop_settle: bad_cycles=%0d required=0", bad); end
    loop = 0;
  endtask

  task automatic test_write_ignored();
    write_entry(0, 2, 3, 0);
    write_entry(1, 0, 2, 1);
    run_trace("wr_busy", 0, 100000, 10, 2);
    run_trace("wr_after", 0, 100000, -1, 0);
  endtask

  task automatic test_start_stop();
    start = 1; stop = 1;
    @(negedge clk);
    start = 0; stop = 0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL startstop_busy0: actual=%b required=0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL startstop_busy1: actual=%b required=0", busy); end
  endtask

  task automatic test_no_last_reset();
    write_entry(0, 1, 1, 0);
    write_entry(1, 3, 1, 0);
    write_entry(2, 0, 1, 0);
    write_entry(3, 2, 2, 0);
    run_trace("nolast", 0, 100000, -1, 0);
    loop = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || (spkp ^ spkm) !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_play: busy=%b pins=%b required busy=1 one pin high", busy, {spkp, spkm});
    end
    #2 resetn = 0;
    #1;
    checks++; if ({spkp, spkm} !== 2'b00) begin failures++; $display("FAIL async_reset_pins: actual=%b required=00", {spkp, spkm}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_reset_busy: actual=%b required=0", busy); end
    checks++; if (note_idx !== 2'd0) begin failures++; $display("FAIL async_reset_idx: actual=%0d required=0", note_idx); end
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
    run_trace("replay", 0, 100000, -1, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 4; a++) begin
        write_entry(a, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                    $urandom_range(0, 3) == 0);
      end
      run_trace($sformatf("rand%0d", r), 0, 100000, -1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skip();
    test_loop_stop();
    test_write_ignored();
    test_start_stop();
    test_no_last_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
